// File: rtl/vg_pkg.sv
// Shared definitions for the video mode controller.
// Register map, FSM encoding and power-on timing set.
package vg_pkg;

  localparam int N_REGS = 9;

  localparam logic [3:0] A_H_TOTAL   = 4'd0;
  localparam logic [3:0] A_H_FP      = 4'd1;
  localparam logic [3:0] A_H_BP      = 4'd2;
  localparam logic [3:0] A_H_SYNC    = 4'd3;
  localparam logic [3:0] A_V_TOTAL   = 4'd4;
  localparam logic [3:0] A_V_FP      = 4'd5;
  localparam logic [3:0] A_V_BP      = 4'd6;
  localparam logic [3:0] A_V_SYNC    = 4'd7;
  localparam logic [3:0] A_HV_OFFSET = 4'd8;

  localparam int DEF_H_TOTAL   = 2200;
  localparam int DEF_H_FP      = 88;
  localparam int DEF_H_BP      = 148;
  localparam int DEF_H_SYNC    = 44;
  localparam int DEF_V_TOTAL   = 1125;
  localparam int DEF_V_FP      = 4;
  localparam int DEF_V_BP      = 36;
  localparam int DEF_V_SYNC    = 5;
  localparam int DEF_HV_OFFSET = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_FRAME,
    S_APPLY,
    S_HOLD
  } vg_state_e;

endpackage

// File: rtl/vg_mode_check.sv
// Combinational sanity check of a candidate timing set.
// Sums are widened by two bits so three fields cannot wrap.
module vg_mode_check #(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12
) (
  input  logic [X_BITS-1:0] h_total,
  input  logic [X_BITS-1:0] h_fp,
  input  logic [X_BITS-1:0] h_bp,
  input  logic [X_BITS-1:0] h_sync,
  input  logic [X_BITS-1:0] hv_offset,
  input  logic [Y_BITS-1:0] v_total,
  input  logic [Y_BITS-1:0] v_fp,
  input  logic [Y_BITS-1:0] v_bp,
  input  logic [Y_BITS-1:0] v_sync,
  output logic              ok
);

  localparam int XW = X_BITS + 2;
  localparam int YW = Y_BITS + 2;

  logic [XW-1:0] h_sum;
  logic [YW-1:0] v_sum;

  // Blanking must fit inside the line/frame and sync must be non-empty
  always_comb begin
    h_sum = XW'(h_sync) + XW'(h_bp) + XW'(h_fp);
    v_sum = YW'(v_sync) + YW'(v_bp) + YW'(v_fp);
    ok = (h_sum < XW'(h_total))
      && (h_sync != '0)
      && (hv_offset < h_total)
      && (v_sum < YW'(v_total))
      && (v_sync != '0);
  end

endmodule

// File: rtl/video_mode_ctrl.sv
// Shadow/active timing registers with frame-aligned apply.
// New modes are validated, then swapped in on a vsync edge.
module video_mode_ctrl
  import vg_pkg::*;
#(
  parameter int X_BITS    = 12,
  parameter int Y_BITS    = 12,
  parameter int RST_CYC   = 4,
  parameter int TO_BITS   = 22,
  parameter int H_TOTAL   = DEF_H_TOTAL,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_BP      = DEF_H_BP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int V_TOTAL   = DEF_V_TOTAL,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_BP      = DEF_V_BP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int HV_OFFSET = DEF_HV_OFFSET,
  localparam int D_BITS   = (X_BITS > Y_BITS) ? X_BITS : Y_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_addr,
  input  logic [D_BITS-1:0] cfg_data,
  input  logic              cfg_commit,
  input  logic              vs_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              vg_reset,
  output logic [X_BITS-1:0] h_total,
  output logic [X_BITS-1:0] h_fp,
  output logic [X_BITS-1:0] h_bp,
  output logic [X_BITS-1:0] h_sync,
  output logic [X_BITS-1:0] hv_offset,
  output logic [Y_BITS-1:0] v_total,
  output logic [Y_BITS-1:0] v_fp,
  output logic [Y_BITS-1:0] v_bp,
  output logic [Y_BITS-1:0] v_sync
);

  localparam int RC_BITS = $clog2(RST_CYC + 1);

  localparam logic [D_BITS-1:0] DEF [N_REGS] = '{
    D_BITS'(H_TOTAL), D_BITS'(H_FP), D_BITS'(H_BP),
    D_BITS'(H_SYNC), D_BITS'(V_TOTAL), D_BITS'(V_FP),
    D_BITS'(V_BP), D_BITS'(V_SYNC), D_BITS'(HV_OFFSET)
  };

  vg_state_e          state_q, state_d;
  logic [D_BITS-1:0]  sh_q [N_REGS];
  logic [D_BITS-1:0]  sh_d [N_REGS];
  logic [D_BITS-1:0]  act_q [N_REGS];
  logic [D_BITS-1:0]  act_d [N_REGS];
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               vg_reset_q, vg_reset_d;
  logic               vs_dly_q, vs_dly_d;
  logic [TO_BITS-1:0] to_q, to_d, to_inc;
  logic [RC_BITS-1:0] rc_q, rc_d;
  logic               vs_rise;
  logic               mode_ok;

  vg_mode_check #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_check (
    .h_total   (sh_q[A_H_TOTAL][X_BITS-1:0]),
    .h_fp      (sh_q[A_H_FP][X_BITS-1:0]),
    .h_bp      (sh_q[A_H_BP][X_BITS-1:0]),
    .h_sync    (sh_q[A_H_SYNC][X_BITS-1:0]),
    .hv_offset (sh_q[A_HV_OFFSET][X_BITS-1:0]),
    .v_total   (sh_q[A_V_TOTAL][Y_BITS-1:0]),
    .v_fp      (sh_q[A_V_FP][Y_BITS-1:0]),
    .v_bp      (sh_q[A_V_BP][Y_BITS-1:0]),
    .v_sync    (sh_q[A_V_SYNC][Y_BITS-1:0]),
    .ok        (mode_ok)
  );

  assign vs_rise = vs_in & ~vs_dly_q;
  assign to_inc  = to_q + TO_BITS'(1);

  // Next-state: shadow writes, validation, frame wait and apply/hold
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    act_d      = act_q;
    err_d      = err_q;
    done_d     = 1'b0;
    vg_reset_d = vg_reset_q;
    vs_dly_d   = vs_in;
    to_d       = to_q;
    rc_d       = rc_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_wr && (cfg_addr <= A_HV_OFFSET)) begin
          sh_d[cfg_addr] = cfg_data;
        end
        if (cfg_commit) begin
          state_d = S_CHECK;
          err_d   = 1'b0;
        end
      end
      S_CHECK: begin
        if (mode_ok) begin
          state_d = S_WAIT_FRAME;
          to_d    = '0;
        end else begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_WAIT_FRAME: begin
        to_d = to_inc;
        if (vs_rise || (to_inc == '1)) begin
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        act_d      = sh_q;
        vg_reset_d = 1'b1;
        rc_d       = '0;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (rc_q == RC_BITS'(RST_CYC - 1)) begin
          vg_reset_d = 1'b0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else begin
          rc_d = rc_q + RC_BITS'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register update; reset restores the power-on mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      vg_reset_q <= 1'b0;
      vs_dly_q   <= 1'b0;
      to_q       <= '0;
      rc_q       <= '0;
      for (int i = 0; i < N_REGS; i++) begin
        sh_q[i]  <= DEF[i];
        act_q[i] <= DEF[i];
      end
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      done_q     <= done_d;
      vg_reset_q <= vg_reset_d;
      vs_dly_q   <= vs_dly_d;
      to_q       <= to_d;
      rc_q       <= rc_d;
      sh_q       <= sh_d;
      act_q      <= act_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign vg_reset  = vg_reset_q;
  assign h_total   = act_q[A_H_TOTAL][X_BITS-1:0];
  assign h_fp      = act_q[A_H_FP][X_BITS-1:0];
  assign h_bp      = act_q[A_H_BP][X_BITS-1:0];
  assign h_sync    = act_q[A_H_SYNC][X_BITS-1:0];
  assign hv_offset = act_q[A_HV_OFFSET][X_BITS-1:0];
  assign v_total   = act_q[A_V_TOTAL][Y_BITS-1:0];
  assign v_fp      = act_q[A_V_FP][Y_BITS-1:0];
  assign v_bp      = act_q[A_V_BP][Y_BITS-1:0];
  assign v_sync    = act_q[A_V_SYNC][Y_BITS-1:0];

endmodule

// File: doc/video_mode_ctrl.md
VIDEO_MODE_CTRL -- requirements
Module: video_mode_ctrl

Interface
REQ-001 Parameter X_BITS, default 12: horizontal timing width.
REQ-002 Parameter Y_BITS, default 12: vertical timing width.
REQ-003 Parameter RST_CYC, default 4: number of cycles vg_reset is held after apply.
REQ-004 Parameter TO_BITS, default 22: width of the frame-wait timeout counter.
REQ-005 Parameters H_TOTAL/H_FP/H_BP/H_SYNC, defaults 2200/88/148/44, and V_TOTAL/V_FP/V_BP/V_SYNC, defaults 1125/4/36/5, with HV_OFFSET default 0: reset timing values.
REQ-006 Port clk, input, 1: sole clock.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 cfg_wr, input, 1: writes cfg_data to the shadow register at cfg_addr.
REQ-009 cfg_addr, input, 4: map 0 h_total, 1 h_fp, 2 h_bp, 3 h_sync, 4 v_total, 5 v_fp, 6 v_bp, 7 v_sync, 8 hv_offset; 9-15 ignored.
REQ-010 cfg_data, input, max(X_BITS,Y_BITS): write data, low bits used per field.
REQ-011 cfg_commit, input, 1: request to apply the shadow set.
REQ-012 vs_in, input, 1: vertical sync from the timing generator.
REQ-013 busy, output, 1: high from commit acceptance until done.
REQ-014 done, output, 1: one-cycle pulse on apply completion.
REQ-015 err, output, 1: sticky flag for the last rejected commit.
REQ-016 vg_reset, output, 1: reset to the timing generator.
REQ-017 h_total, h_fp, h_bp, h_sync, hv_offset (X_BITS) and v_total, v_fp, v_bp, v_sync (Y_BITS), outputs: active timing set.

Function
REQ-018 FSM states: IDLE, CHECK, WAIT_FRAME, APPLY, HOLD.
REQ-019 Shadow writes are accepted only in IDLE; writes in other states are dropped.
REQ-020 cfg_commit in IDLE moves to CHECK next cycle and clears err; a same-cycle cfg_wr is included in validation.
REQ-021 cfg_commit outside IDLE is ignored; err and the FSM are unaffected.
REQ-022 CHECK evaluates at X_BITS+2/Y_BITS+2 width: h_sync+h_bp+h_fp < h_total, h_sync != 0, hv_offset < h_total; v_sync+v_bp+v_fp < v_total, v_sync != 0.
REQ-023 On CHECK failure: set err=1, go to IDLE; active outputs are unchanged and done is not asserted.
REQ-024 On CHECK pass: go to WAIT_FRAME and clear the timeout counter.
REQ-025 WAIT_FRAME exits to APPLY on a vs_in rising edge (vs_in registered once, edge = vs_in & ~vs_d) detected while in WAIT_FRAME, or when the timeout counter reaches all-ones.
REQ-026 APPLY copies the shadow set to the active outputs at the next edge, raises vg_reset, and moves to HOLD.
REQ-027 vg_reset stays high exactly RST_CYC cycles; HOLD then exits to IDLE with done=1 for one cycle, and busy falls in that same cycle.
REQ-028 busy = (state != IDLE).
REQ-029 Active outputs change only in APPLY, never mid-frame otherwise.

Reset
REQ-030 Reset loads shadow and active sets with the parameter defaults, sets state IDLE, and sets busy=0, done=0, err=0, vg_reset=0, vs_d=0 and the timeout counter to 0.
REQ-031 Reset asserted mid-operation (any state) aborts immediately; no partial apply survives.

Structure
REQ-032 Shared package vg_pkg holds the address map constants, state encoding and default timing constants.
REQ-033 Validation logic is the sub-module vg_mode_check (combinational, returns ok).

Verification
REQ-034 Cover: write h_total=1650, h_fp=110, h_bp=220, h_sync=40, v_total=750, v_fp=5, v_bp=20, v_sync=5, then commit, then a vs_in rise -> outputs update, vg_reset high 4 cycles, done pulses, err=0.
REQ-035 Cover: h_sync=0, then commit -> err=1 one cycle after CHECK, outputs keep 2200/88/148/44, no done.
REQ-036 Cover: commit, then hold vs_in low with TO_BITS=4 -> apply after 15 WAIT cycles.
REQ-037 Cover: cfg_wr addr0=1000 with commit in the same cycle -> CHECK uses 1000; cfg_wr while busy -> shadow unchanged.
REQ-038 Cover: reset asserted during HOLD -> vg_reset=0, busy=0 and outputs at defaults asynchronously.
